// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the slave and the master: word width, bit-count width
// and the frame state encoding.
package spi_pkg;

  localparam int unsigned WordWidth = 16;
  localparam int unsigned CntWidth  = 5;

  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(WordWidth);
  localparam logic [CntWidth-1:0] CntSat  = CntWidth'(WordWidth + 1);

  typedef logic [WordWidth-1:0] spi_word_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StStrobe = 2'd2
  } spi_state_e;

  // Bit count stops at one past a full word so over-long frames never alias to a good count.
  function automatic logic [CntWidth-1:0] cnt_inc(input logic [CntWidth-1:0] cnt);
    return (cnt >= CntSat) ? CntSat : cnt + CntOne;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer into the clk domain with asynchronous active-low clear.
// SYNC_STAGES must be at least 2.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave: 16-bit full-duplex frames terminated by a strobe from the master.
// Define SPI_SLAVE_FRAME_ERR_EN to report frames whose bit count is not 16 on frame_err.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  input  logic                 spi_str,
  output logic                 spi_miso,
  input  logic [WordWidth-1:0] din,
  input  logic                 din_load,
  output logic [WordWidth-1:0] dout,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  logic clk_s, mosi_s, str_s;
  logic clk_s_q, str_s_q;
  logic clk_rise, clk_fall, str_rise, str_fall;

  spi_state_e          state_q;
  spi_word_t           rx_q, tx_q, pend_q, dout_q;
  spi_word_t           pend_next;
  logic [CntWidth-1:0] cnt_q;
  logic                rx_valid_q, busy_q;
  logic                word_ok;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .d     (spi_clk),
    .q     (clk_s)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (spi_mosi),
    .q     (mosi_s)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_str (
    .clk   (clk),
    .reset (reset),
    .d     (spi_str),
    .q     (str_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s_q <= 1'b0;
      str_s_q <= 1'b0;
    end else begin
      clk_s_q <= clk_s;
      str_s_q <= str_s;
    end
  end

  assign clk_rise = clk_s & ~clk_s_q;
  assign clk_fall = ~clk_s & clk_s_q;
  assign str_rise = str_s & ~str_s_q;
  assign str_fall = ~str_s & str_s_q;

  // A same-cycle load must win over the stored word so a reload never picks up a stale value.
  assign pend_next = din_load ? din : pend_q;
  assign word_ok   = (cnt_q == CntFull);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rx_q       <= '0;
      tx_q       <= '0;
      dout_q     <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (str_rise) begin
            state_q <= StStrobe;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= ~word_ok;
`endif
          end else if (clk_rise) begin
            rx_q    <= {rx_q[WordWidth-2:0], mosi_s};
            cnt_q   <= cnt_inc(cnt_q);
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            // Between frames the shift register tracks the pending word; it freezes once a
            // frame starts, so bit 15 is already on spi_miso for the master's first sample.
            tx_q <= pend_next;
          end
        end

        StShift: begin
          if (str_rise) begin
            state_q <= StStrobe;
            if (word_ok) begin
              dout_q     <= rx_q;
              rx_valid_q <= 1'b1;
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= ~word_ok;
`endif
          end else begin
            if (clk_rise) begin
              rx_q  <= {rx_q[WordWidth-2:0], mosi_s};
              cnt_q <= cnt_inc(cnt_q);
            end
            if (clk_fall) begin
              tx_q <= {tx_q[WordWidth-2:0], 1'b0};
            end
          end
        end

        StStrobe: begin
          if (str_fall) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tx_q    <= pend_next;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign spi_miso = tx_q[WordWidth-1];
  assign dout     = dout_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames plus randomized frames, checked against a
// word-level model of the pending/received registers.
module tb_spi_slave;

  localparam int SyncStages = 2;
  localparam int Half       = 12;  // spi_clk half period in clk cycles (~1 MHz at 25 MHz clk)

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int ErrEn = 1;
`else
  localparam int ErrEn = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_mosi, spi_str, spi_miso;
  logic [15:0] din, dout;
  logic        din_load, rx_valid, frame_err, busy;

  spi_slave #(.SYNC_STAGES(SyncStages)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_str   (spi_str),
    .spi_miso  (spi_miso),
    .din       (din),
    .din_load  (din_load),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid, n_err, valid_cyc, str_cyc;
  logic [63:0] cap;

  // Word-level reference: the word queued for transmit and the last good received word.
  logic [15:0] m_pend, m_dout;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        n_valid++;
        valid_cyc = cyc;
      end
      if (frame_err) n_err++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    din      = v;
    din_load = 1'b1;
    @(negedge clk);
    din_load = 1'b0;
    m_pend   = v;
  endtask

  // Master drives mosi during the low phase and samples miso at its own rising edge.
  task automatic spi_bit(input logic b);
    spi_mosi = b;
    tick(Half);
    spi_clk = 1'b1;
    cap = {cap[62:0], spi_miso};
    tick(Half);
    spi_clk = 1'b0;
  endtask

  task automatic strobe();
    tick(Half);
    spi_str = 1'b1;
    str_cyc = cyc;
    tick(Half);
    spi_str = 1'b0;
    tick(8);
  endtask

  task automatic clear_mon();
    n_valid   = 0;
    n_err     = 0;
    valid_cyc = -1;
    cap       = '0;
  endtask

  function automatic logic [63:0] exp_miso(input logic [15:0] tx, input int nbits);
    logic [63:0] e;
    e = '0;
    for (int i = 0; i < nbits; i++) e = {e[62:0], (i < 16) ? tx[15-i] : 1'b0};
    return e;
  endfunction

  task automatic run_frame(input string tag, input logic [15:0] w, input int nbits,
                           input int load_bit, input logic [15:0] load_val);
    logic [15:0] tx;
    tx = m_pend;
    clear_mon();
    for (int i = 0; i < nbits; i++) begin
      if (i == load_bit) load(load_val);
      spi_bit((i < 16) ? w[15-i] : 1'b0);
      if (i == 0) check({tag, ".busy_hi"}, 64'(busy), 64'd1);
    end
    strobe();
    if (nbits == 16) m_dout = w;
    check({tag, ".miso"}, cap, exp_miso(tx, nbits));
    check({tag, ".dout"}, 64'(dout), 64'(m_dout));
    check({tag, ".rx_valid"}, 64'(n_valid), (nbits == 16) ? 64'd1 : 64'd0);
    check({tag, ".frame_err"}, 64'(n_err), (nbits != 16 && ErrEn != 0) ? 64'd1 : 64'd0);
    if (nbits == 16) check({tag, ".latency"}, 64'(valid_cyc - str_cyc), 64'(SyncStages + 1));
    check({tag, ".busy_lo"}, 64'(busy), 64'd0);
  endtask

  int nb_tab[5] = '{16, 16, 16, 15, 17};

  initial begin
    reset    = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_str  = 1'b0;
    din      = '0;
    din_load = 1'b0;
    m_pend   = '0;
    m_dout   = '0;
    clear_mon();
    tick(3);
    check("rst.dout", 64'(dout), 64'd0);
    check("rst.rx_valid", 64'(rx_valid), 64'd0);
    check("rst.frame_err", 64'(frame_err), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.miso", 64'(spi_miso), 64'd0);
    reset = 1'b1;
    tick(4);

    load(16'hA5C3);
    run_frame("basic", 16'h1234, 16, -1, 16'h0);
    run_frame("repeat", 16'($urandom), 16, -1, 16'h0);
    run_frame("short12", 16'($urandom), 12, -1, 16'h0);

    load(16'h0000);
    run_frame("load_mid", 16'($urandom), 16, 5, 16'hFFFF);
    run_frame("after_load", 16'($urandom), 16, -1, 16'h0);

    run_frame("long18", 16'($urandom), 18, -1, 16'h0);
    run_frame("long48", 16'($urandom), 48, -1, 16'h0);

    // Reset after eight bits: outputs clear at once, the tail is a new (short) frame.
    load(16'($urandom) | 16'h8000);
    clear_mon();
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst.dout", 64'(dout), 64'd0);
    check("arst.busy", 64'(busy), 64'd0);
    check("arst.miso", 64'(spi_miso), 64'd0);
    check("arst.rx_valid", 64'(rx_valid), 64'd0);
    check("arst.frame_err", 64'(frame_err), 64'd0);
    m_pend = '0;
    m_dout = '0;
    tick(2);
    reset = 1'b1;
    tick(2);
    clear_mon();
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom));
    strobe();
    check("arst_tail.miso", cap, 64'd0);
    check("arst_tail.rx_valid", 64'(n_valid), 64'd0);
    check("arst_tail.frame_err", 64'(n_err), 64'(ErrEn));
    check("arst_tail.dout", 64'(dout), 64'd0);

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) load(16'($urandom));
      run_frame($sformatf("rand%0d", k), 16'($urandom), nb_tab[$urandom_range(0, 4)], -1,
                16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
